// File: rtl/spi_pkg.sv
// Constants shared by the SPI word serialiser and its receive stage.
package spi_pkg;
  localparam int SPI_WORD_W      = 16;
  localparam int SPI_SYNC_STAGES = 2;
  localparam int SPI_FIFO_DEPTH  = 4;
endpackage

// File: rtl/spi_rx_fifo.sv
// Synchronous word FIFO with registered pointers and an explicit level counter.
module spi_rx_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [LVL_W-1:0]  o_level,
  output logic              o_drop
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              w_wr;
  logic              w_rd;

  assign o_full    = (r_level == LVL_W'(DEPTH));
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rd_data = r_mem[r_rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign w_rd   = i_pop && !o_empty;
  assign w_wr   = i_push && (!o_full || w_rd);
  assign o_drop = i_push && o_full && !w_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr && !w_rd)      r_level <= r_level + LVL_W'(1);
      else if (!w_wr && w_rd) r_level <= r_level - LVL_W'(1);
    end
  end
endmodule

// File: rtl/spi_slave_rx.sv
// SPI receive stage: synchronises cs/sclk/data, deserialises MSB-first words on rising
// sclk and buffers them in a FIFO; flags partial frames and overflow.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int DATA_W      = SPI_WORD_W,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES,
  parameter int FIFO_DEPTH  = SPI_FIFO_DEPTH,
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs_l,
  input  logic              spi_sclk,
  input  logic              spi_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LVL_W-1:0]  fifo_level,
  output logic              overflow,
  output logic              frame_err,
  input  logic              clr_err
);
  localparam int CNT_W  = $clog2(DATA_W);
  localparam int WARM_N = SYNC_STAGES + 1;
  localparam int WARM_W = $clog2(WARM_N + 1);

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_cs_d;
  logic                   r_sclk_d;
  logic [WARM_W-1:0]      r_warm;
  logic                   r_armed;
  logic [DATA_W-1:0]      r_shift;
  logic [CNT_W-1:0]       r_bit_cnt;
  logic                   r_push;
  logic                   r_frame_err;
  logic                   r_overflow;

  logic w_cs;
  logic w_sclk;
  logic w_data;
  logic w_warm;
  logic w_sclk_rise;
  logic w_cs_fall;
  logic w_cs_rise;
  logic w_empty;
  logic w_full;
  logic w_drop;

  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_data = r_data_sync[SYNC_STAGES-1];

  // Edges are suppressed until the chains hold only post-reset samples, so a cs_l that
  // is already low when reset drops cannot look like a fresh frame start.
  assign w_warm      = (r_warm == WARM_W'(WARM_N));
  assign w_sclk_rise = w_warm && w_sclk && !r_sclk_d;
  assign w_cs_fall   = w_warm && !w_cs && r_cs_d;
  assign w_cs_rise   = w_warm && w_cs && !r_cs_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs_sync   <= '1;
      r_sclk_sync <= '0;
      r_data_sync <= '0;
      r_cs_d      <= 1'b1;
      r_sclk_d    <= 1'b0;
      r_warm      <= '0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_l};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], spi_data};
      r_cs_d      <= w_cs;
      r_sclk_d    <= w_sclk;
      if (!w_warm) r_warm <= r_warm + WARM_W'(1);
    end
  end

  // The completed word stays in r_shift while r_push is high, so it feeds the FIFO directly.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed     <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_push      <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_cs_fall) begin
        r_armed   <= 1'b1;
        r_bit_cnt <= '0;
      end else if (w_cs_rise) begin
        if (r_bit_cnt != '0) r_frame_err <= 1'b1;
        r_bit_cnt <= '0;
      end else if (w_sclk_rise && r_armed && !w_cs) begin
        r_shift <= {r_shift[DATA_W-2:0], w_data};
        if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
          r_bit_cnt <= '0;
          r_push    <= 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)        r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (clr_err) r_overflow <= 1'b0;
  end

  spi_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .i_push      (r_push),
    .i_push_data (r_shift),
    .i_pop       (out_ready),
    .o_rd_data   (out_data),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (fifo_level),
    .o_drop      (w_drop)
  );

  assign out_valid = !w_empty;
  assign overflow  = r_overflow;
  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_spi_slave_rx.sv
// Scenario bench for spi_slave_rx: directed frames plus randomized bursts against a queue model.
module tb_spi_slave_rx;
  logic        clk = 1'b0;
  logic        reset;
  logic        spi_cs_l;
  logic        spi_sclk;
  logic        spi_data;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        frame_err;
  logic        clr_err;

  int n_cmp = 0;
  int n_bad = 0;
  int ferr_cnt = 0;

  always #5 clk = ~clk;

  // Counts clock cycles during which frame_err is high.
  always @(posedge clk) if (frame_err === 1'b1) ferr_cnt++;

  spi_slave_rx dut (
    .clk        (clk),
    .reset      (reset),
    .spi_cs_l   (spi_cs_l),
    .spi_sclk   (spi_sclk),
    .spi_data   (spi_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .clr_err    (clr_err)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cs_down();
    spi_sclk = 1'b0;
    spi_cs_l = 1'b0;
    tick(4);
  endtask

  task automatic cs_up();
    spi_sclk = 1'b0;
    tick(3);
    spi_cs_l = 1'b1;
    tick(6);
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      spi_data = w[15-i];
      spi_sclk = 1'b0;
      tick(3);
      spi_sclk = 1'b1;
      tick(3);
    end
    spi_sclk = 1'b0;
  endtask

  task automatic send_frame(input logic [15:0] w);
    cs_down();
    send_bits(w, 16);
    cs_up();
  endtask

  // Pops one word with a bounded wait; ok=0 means nothing became available.
  task automatic pop_word(output logic [15:0] w, output bit ok);
    int g;
    g = 0;
    tick($urandom_range(0, 2));
    out_ready = 1'b1;
    while (out_valid !== 1'b1 && g < 50) begin
      tick(1);
      g++;
    end
    ok = (out_valid === 1'b1);
    w  = out_data;
    tick(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; spi_cs_l = 1'b1; spi_sclk = 1'b0; spi_data = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    tick(3);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0000", out_data); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_cmp++; if (frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    reset = 1'b0;
    tick(6);
  endtask

  task automatic test_single();
    logic [15:0] w;
    int f0;
    w = 16'hA5C3;
    f0 = ferr_cnt;
    out_ready = 1'b1;
    cs_down();
    send_bits(w, 15);
    spi_data = w[0];
    spi_sclk = 1'b0;
    tick(3);
    spi_sclk = 1'b1;
    tick(3);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: valid %b want 0 after 3 edges", out_valid); end
    tick(1);
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== w || fifo_level !== 3'd1) begin
      n_bad++; $display("FAIL single_word: valid %b data %h level %0d want 1 %h 1", out_valid, out_data, fifo_level, w);
    end
    tick(1);
    n_cmp++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      n_bad++; $display("FAIL single_pulse: valid %b level %0d want 0 0", out_valid, fifo_level);
    end
    out_ready = 1'b0;
    cs_up();
    n_cmp++; if (ferr_cnt !== f0) begin n_bad++; $display("FAIL single_ferr: got %0d want %0d", ferr_cnt, f0); end
  endtask

  task automatic test_overflow();
    logic [15:0] got;
    bit ok;
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(16'(i));
    n_cmp++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL ovf_fill: level %0d ovf %b want 4 0", fifo_level, overflow);
    end
    send_frame(16'hFFFF);
    n_cmp++;
    if (fifo_level !== 3'd4 || overflow !== 1'b1) begin
      n_bad++; $display("FAIL ovf_set: level %0d ovf %b want 4 1", fifo_level, overflow);
    end
    for (int i = 1; i <= 4; i++) begin
      pop_word(got, ok);
      n_cmp++;
      if (!ok || got !== 16'(i)) begin n_bad++; $display("FAIL ovf_drain: ok %b got %h want %h", ok, got, 16'(i)); end
    end
    tick(2);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ovf_empty: valid %b want 0", out_valid); end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", overflow); end
  endtask

  task automatic test_frame_err();
    logic [15:0] got;
    bit ok;
    int f0;
    f0 = ferr_cnt;
    cs_down();
    send_bits(16'($urandom), 7);
    cs_up();
    n_cmp++; if (ferr_cnt !== f0 + 1) begin n_bad++; $display("FAIL ferr_pulse: high cycles %0d want 1", ferr_cnt - f0); end
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL ferr_nopush: level %0d want 0", fifo_level); end
    f0 = ferr_cnt;
    send_frame(16'h1234);
    n_cmp++; if (ferr_cnt !== f0) begin n_bad++; $display("FAIL ferr_clean: high cycles %0d want 0", ferr_cnt - f0); end
    pop_word(got, ok);
    n_cmp++; if (!ok || got !== 16'h1234) begin n_bad++; $display("FAIL ferr_next: ok %b got %h want 1234", ok, got); end
  endtask

  task automatic test_full_pop();
    logic [15:0] w [5];
    logic [15:0] got;
    bit ok;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      w[i] = 16'($urandom);
      send_frame(w[i]);
    end
    w[4] = 16'hBEEF;
    cs_down();
    send_bits(w[4], 15);
    spi_data = w[4][0];
    spi_sclk = 1'b0;
    tick(3);
    spi_sclk = 1'b1;
    tick(3);
    out_ready = 1'b1;
    n_cmp++;
    if (fifo_level !== 3'd4 || out_data !== w[0]) begin
      n_bad++; $display("FAIL fullpop_pre: level %0d head %h want 4 %h", fifo_level, out_data, w[0]);
    end
    tick(1);
    out_ready = 1'b0;
    n_cmp++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      n_bad++; $display("FAIL fullpop_same: level %0d ovf %b want 4 0", fifo_level, overflow);
    end
    cs_up();
    for (int i = 1; i < 5; i++) begin
      pop_word(got, ok);
      n_cmp++;
      if (!ok || got !== w[i]) begin n_bad++; $display("FAIL fullpop_drain: ok %b got %h want %h", ok, got, w[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    logic [15:0] got;
    bit ok;
    int f0;
    w = 16'hC39A;
    cs_down();
    send_bits(w, 8);
    reset = 1'b1;
    tick(2);
    n_cmp++;
    if ({out_valid, out_data, fifo_level, overflow, frame_err} !== '0) begin
      n_bad++; $display("FAIL midreset_out: valid %b data %h level %0d ovf %b ferr %b want all 0",
                        out_valid, out_data, fifo_level, overflow, frame_err);
    end
    reset = 1'b0;
    tick(2);
    f0 = ferr_cnt;
    send_bits({w[7:0], 8'h00}, 8);
    tick(6);
    n_cmp++; if (fifo_level !== 3'd0) begin n_bad++; $display("FAIL midreset_ignore: level %0d want 0", fifo_level); end
    cs_up();
    n_cmp++; if (ferr_cnt !== f0) begin n_bad++; $display("FAIL midreset_ferr: high cycles %0d want 0", ferr_cnt - f0); end
    send_frame(16'h5A5A);
    pop_word(got, ok);
    n_cmp++; if (!ok || got !== 16'h5A5A) begin n_bad++; $display("FAIL midreset_next: ok %b got %h want 5a5a", ok, got); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    bit ok;
    int f0;
    f0 = ferr_cnt;
    out_ready = 1'b0;
    cs_down();
    send_bits(16'h0F0F, 16);
    send_bits(16'hF0F0, 16);
    cs_up();
    n_cmp++; if (fifo_level !== 3'd2) begin n_bad++; $display("FAIL b2b_level: got %0d want 2", fifo_level); end
    n_cmp++; if (ferr_cnt !== f0) begin n_bad++; $display("FAIL b2b_ferr: high cycles %0d want 0", ferr_cnt - f0); end
    pop_word(got, ok);
    n_cmp++; if (!ok || got !== 16'h0F0F) begin n_bad++; $display("FAIL b2b_w0: ok %b got %h want 0f0f", ok, got); end
    pop_word(got, ok);
    n_cmp++; if (!ok || got !== 16'hF0F0) begin n_bad++; $display("FAIL b2b_w1: ok %b got %h want f0f0", ok, got); end
  endtask

  // Model: a queue of words in send order; the FIFO keeps the first four, anything beyond is lost.
  task automatic test_random();
    logic [15:0] q[$];
    logic [15:0] w;
    logic [15:0] exp;
    logic [15:0] got;
    bit ok;
    int n, f0, f_exp, kept;
    bit b2b;
    for (int it = 0; it < 8; it++) begin
      q.delete();
      out_ready = 1'b0;
      f0 = ferr_cnt;
      f_exp = 0;
      if ($urandom_range(0, 1) == 1) begin
        cs_down();
        send_bits(16'($urandom), $urandom_range(1, 15));
        cs_up();
        f_exp = 1;
      end
      n = $urandom_range(1, 6);
      b2b = 1'($urandom_range(0, 1));
      if (b2b) cs_down();
      for (int k = 0; k < n; k++) begin
        w = 16'($urandom);
        if (q.size() < 4) q.push_back(w);
        if (b2b) send_bits(w, 16);
        else send_frame(w);
      end
      if (b2b) cs_up();
      kept = q.size();
      n_cmp++;
      if (fifo_level !== 3'(kept) || overflow !== (n > 4) || ferr_cnt !== f0 + f_exp) begin
        n_bad++; $display("FAIL rand_state: level %0d ovf %b ferr %0d want %0d %b %0d",
                          fifo_level, overflow, ferr_cnt - f0, kept, (n > 4), f_exp);
      end
      while (q.size() > 0) begin
        exp = q.pop_front();
        pop_word(got, ok);
        n_cmp++;
        if (!ok || got !== exp) begin n_bad++; $display("FAIL rand_word: ok %b got %h want %h", ok, got, exp); end
      end
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_frame_err();
    test_full_pop();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "time limit");
  end
endmodule
